// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and defaults for the LC-3 memory arbiter
package lc3_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic {
    IDLE,
    VID_BURST
  } arb_state_t;

  typedef enum logic {
    CPU,
    VID
  } served_t;

endpackage

// File: rtl/burst_addr_gen.sv
// rtl/burst_addr_gen.sv - video burst address and word counter
module burst_addr_gen #(
  parameter int ADDR_W    = 16,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam int CNT_W = $clog2(BURST_LEN);

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // The address adder simply overflows, so 0xFFFF steps to 0x0000.
  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = base_i;
      cnt_d  = '0;
    end else if (step_i) begin
      addr_d = addr_q + ADDR_W'(1);
      cnt_d  = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of one RAM port between the CPU and video scan-out
module ram_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_ptr_to_ptr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_base,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_done,
  output logic              ram_we,
  output logic              ram_ptr_to_ptr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  arb_state_t        state_q, state_d;
  served_t           last_served_q, last_served_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              cpu_valid_q, vid_valid_q, vid_done_q;
  logic              cpu_win;
  logic              burst_load, burst_step, burst_last;
  logic [ADDR_W-1:0] burst_addr;

  burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .BURST_LEN(BURST_LEN)
  ) u_burst_addr_gen (
    .clk   (clk),
    .reset (reset),
    .load_i(burst_load),
    .step_i(burst_step),
    .base_i(vid_base),
    .addr_o(burst_addr),
    .last_o(burst_last)
  );

  always_comb begin
    state_d        = state_q;
    last_served_d  = last_served_q;
    cpu_win        = 1'b0;
    cpu_gnt        = 1'b0;
    vid_gnt        = 1'b0;
    ram_we         = 1'b0;
    ram_ptr_to_ptr = 1'b0;
    ram_addr       = last_addr_q;
    ram_wdata      = '0;
    burst_load     = 1'b0;
    burst_step     = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_win = cpu_req && (!vid_req || (last_served_q == VID));
        if (cpu_win) begin
          cpu_gnt        = 1'b1;
          ram_we         = cpu_we;
          ram_ptr_to_ptr = cpu_ptr_to_ptr;
          ram_addr       = cpu_addr;
          ram_wdata      = cpu_wdata;
          last_served_d  = CPU;
        end else if (vid_req) begin
          vid_gnt       = 1'b1;
          burst_load    = 1'b1;
          last_served_d = VID;
          state_d       = VID_BURST;
        end
      end
      VID_BURST: begin
        ram_addr   = burst_addr;
        burst_step = 1'b1;
        if (burst_last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    last_addr_d = ram_addr;
    // Outputs must read 0 the moment reset asserts, even mid-cycle.
    if (!reset) begin
      cpu_gnt        = 1'b0;
      vid_gnt        = 1'b0;
      ram_we         = 1'b0;
      ram_ptr_to_ptr = 1'b0;
      ram_addr       = '0;
      ram_wdata      = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      last_served_q <= VID;
      last_addr_q   <= '0;
      cpu_valid_q   <= 1'b0;
      vid_valid_q   <= 1'b0;
      vid_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      last_addr_q   <= last_addr_d;
      cpu_valid_q   <= cpu_gnt && !cpu_we;
      vid_valid_q   <= (state_q == VID_BURST);
      vid_done_q    <= (state_q == VID_BURST) && burst_last;
    end
  end

  assign cpu_valid = cpu_valid_q;
  assign vid_valid = vid_valid_q;
  assign vid_done  = vid_done_q;
  assign cpu_rdata = cpu_valid_q ? ram_rdata : '0;
  assign vid_rdata = vid_valid_q ? ram_rdata : '0;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single RAM port between two requesters: the LC-3 CPU (single-word reads/writes, including the PtrToPtr indirect flag) and the framebuffer scan-out engine (fixed-length sequential read bursts).
- Sits between cpu/ram and display logic in lc3computer, replacing the direct cpu-to-ram wiring.
- Round-robin arbitration; video bursts are atomic once granted.

Parameters:
- DATA_W, 16, RAM word width.
- ADDR_W, 16, RAM address width.
- BURST_LEN, 16, words per video burst; legal range is 2..256.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  CPU write enable
- cpu_ptr_to_ptr  in  1  CPU indirect-access flag, forwarded to RAM
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_valid  out  1  CPU read data valid
- cpu_rdata  out  DATA_W  CPU read data
- vid_req  in  1  burst request
- vid_base  in  ADDR_W  burst start address, sampled at grant
- vid_gnt  out  1  one-cycle pulse when a burst is accepted
- vid_valid  out  1  burst data word valid
- vid_rdata  out  DATA_W  burst data
- vid_done  out  1  pulse with the last burst word
- ram_we  out  1  RAM write enable
- ram_ptr_to_ptr  out  1  RAM PtrToPtr
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0, state is IDLE, the burst counter is 0, last_served=VID (so the CPU wins the first tie).
  - Reset during a burst abandons it; vid_done is not pulsed.
- States: IDLE, VID_BURST.
- IDLE:
  - Only cpu_req: cpu_gnt=1 combinationally. ram_addr/ram_we/ram_wdata/ram_ptr_to_ptr mirror the CPU inputs. last_served becomes CPU.
  - Only vid_req: vid_gnt=1. Register burst_addr=vid_base and burst_cnt=0, set last_served=VID, go to VID_BURST. No RAM access is issued this cycle; ram_we=0.
  - Both requesting: grant the requester that is not last_served.
  - Neither requesting: ram_we=0, ram_addr holds its last value.
- VID_BURST:
  - Each cycle: ram_addr=burst_addr, ram_we=0, ram_ptr_to_ptr=0. Then burst_addr increments mod 2^ADDR_W (0xFFFF wraps to 0x0000) and burst_cnt increments.
  - When burst_cnt==BURST_LEN-1, return to IDLE next cycle.
  - cpu_gnt=0 throughout; the CPU stalls with its request held.
  - vid_req changes and vid_base changes are ignored during the burst.
- Read return (registered flags):
  - cpu_valid is 1 the cycle after a CPU grant with cpu_we=0.
  - vid_valid is 1 the cycle after each burst address.
  - vid_done=1 together with the BURST_LEN-th vid_valid.
  - cpu_rdata/vid_rdata equal ram_rdata when their valid is 1, and 0 otherwise.
- CPU writes produce no cpu_valid.
- Latency:
  - CPU: grant in the same cycle as the request if it wins; data 1 cycle later.
  - Video: first data 2 cycles after the vid_gnt cycle; BURST_LEN consecutive words with no gaps.
- Worst-case CPU wait: BURST_LEN+1 cycles. After any burst the CPU wins the next tie.
- Back-to-back CPU-only requests are granted every cycle.
- A CPU write and a burst never coincide.

Decomposition:
- Package lc3_mem_pkg holds ADDR_W/DATA_W defaults, the arb_state_t enum (IDLE, VID_BURST) and the served_t enum (CPU, VID).
- One sub-module, burst_addr_gen: burst_addr and burst_cnt registers, load/step/last outputs, wrap handling.
- Grant mux and valid pipeline stay in ram_arbiter.

Test Plan:
- CPU read only: cpu_req, addr=0x3000, RAM[0x3000]=0xBEEF -> cpu_gnt same cycle, ram_addr=0x3000, cpu_valid and cpu_rdata=0xBEEF next cycle.
- CPU write: cpu_we=1, addr=0x4000, wdata=0x1234, ptr_to_ptr=1 -> ram_we=1, ram_ptr_to_ptr=1 for one cycle, no cpu_valid, RAM[0x4000]=0x1234.
- Video burst alone: vid_base=0xC000, BURST_LEN=16 -> vid_gnt pulse; ram_addr 0xC000..0xC00F on 16 consecutive cycles; 16 vid_valid words matching RAM; vid_done on the 16th.
- Contention: cpu_req and vid_req both asserted from the first cycle after reset -> CPU served first, then burst granted. A CPU request held throughout the burst gets cpu_gnt exactly 1 cycle after the burst's last address, ahead of a repeated vid_req.
- Wrap: vid_base=0xFFF8, BURST_LEN=16 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007.
- Reset mid-burst: assert reset at word 5 -> all outputs 0 immediately, no vid_done. After release, a CPU-only request is granted on its first cycle.
